// File: rtl/pool_ctrl_if.sv
// Signal bundle between pool_ctrl, the control/config registers, the pool unit and its buffers.
interface pool_ctrl_if #(
   parameter int MAX_BITS_POOL = 3,
   parameter int ROW_W         = 8,
   parameter int AW            = 10
) ();
   logic                     start;
   logic                     cfg_pool_en;
   logic [MAX_BITS_POOL-1:0] cfg_kernel_size;
   logic [ROW_W-1:0]         cfg_num_rows;
   logic [AW-1:0]            cfg_src_base;
   logic [AW-1:0]            cfg_dst_base;
   logic                     src_rd_en;
   logic [AW-1:0]            src_rd_addr;
   logic                     pool_enable;
   logic [MAX_BITS_POOL-1:0] pool_kernel_size;
   logic                     pool_in_valid;
   logic                     dst_wr_en;
   logic [AW-1:0]            dst_wr_addr;
   logic                     busy;
   logic                     done;
   logic                     cfg_err;

   modport master (
      output start, cfg_pool_en, cfg_kernel_size, cfg_num_rows, cfg_src_base, cfg_dst_base,
      input  src_rd_en, src_rd_addr, pool_enable, pool_kernel_size, pool_in_valid,
      input  dst_wr_en, dst_wr_addr, busy, done, cfg_err
   );

   modport slave (
      input  start, cfg_pool_en, cfg_kernel_size, cfg_num_rows, cfg_src_base, cfg_dst_base,
      output src_rd_en, src_rd_addr, pool_enable, pool_kernel_size, pool_in_valid,
      output dst_wr_en, dst_wr_addr, busy, done, cfg_err
   );
endinterface

// File: rtl/pool_ctrl.sv
// Pooling-stage sequencer: latches a config on start, issues one source read per row and
// writes each pooled (or bypassed) row to the destination buffer at a fixed pipeline delay.
module pool_ctrl #(
   parameter int MAX_BITS_POOL = 3,
   parameter int ROW_W         = 8,
   parameter int AW            = 10
) (
   input logic        clk,
   input logic        resetn,
   pool_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   function automatic logic kernel_legal(input logic [MAX_BITS_POOL-1:0] k);
      logic ok;
      case (k)
         MAX_BITS_POOL'(1), MAX_BITS_POOL'(2), MAX_BITS_POOL'(4): ok = 1'b1;
         default:                                                  ok = 1'b0;
      endcase
      return ok;
   endfunction

   logic [1:0]               state_r,          state_s;
   logic [ROW_W-1:0]         rem_r,            rem_s;
   logic                     pool_en_r,        pool_en_s;
   logic [MAX_BITS_POOL-1:0] kernel_r,         kernel_s;
   logic                     src_rd_en_r,      src_rd_en_s;
   logic [AW-1:0]            src_rd_addr_r,    src_rd_addr_s;
   logic                     pool_in_valid_r,  pool_in_valid_s;
   logic                     dst_wr_en_r,      dst_wr_en_s;
   logic [AW-1:0]            dst_wr_addr_r,    dst_wr_addr_s;
   logic                     busy_r,           busy_s;
   logic                     done_r,           done_s;
   logic                     cfg_err_r,        cfg_err_s;

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      state_s       = state_r;
      rem_s         = rem_r;
      pool_en_s     = pool_en_r;
      kernel_s      = kernel_r;
      src_rd_en_s   = 1'b0;
      src_rd_addr_s = src_rd_addr_r;
      cfg_err_s     = 1'b0;
      // Writes are contiguous, so the address just advances after every write cycle.
      if (dst_wr_en_r) begin
         dst_wr_addr_s = dst_wr_addr_r + AW'(1);
      end else begin
         dst_wr_addr_s = dst_wr_addr_r;
      end
      case (state_r)
         S_IDLE: begin
            if (bus.start && bus.cfg_pool_en && !kernel_legal(bus.cfg_kernel_size)) begin
               cfg_err_s = 1'b1;
            end else if (bus.start) begin
               pool_en_s     = bus.cfg_pool_en;
               kernel_s      = bus.cfg_kernel_size;
               src_rd_addr_s = bus.cfg_src_base;
               dst_wr_addr_s = bus.cfg_dst_base;
               if (bus.cfg_num_rows == {ROW_W{1'b0}}) begin
                  state_s = S_FIN;
               end else begin
                  state_s     = S_ISSUE;
                  src_rd_en_s = 1'b1;
                  rem_s       = bus.cfg_num_rows - ROW_W'(1);
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ISSUE: begin
            // rem_r counts reads still to issue after the current one, so N=2^ROW_W-1 fits.
            if (rem_r == {ROW_W{1'b0}}) begin
               state_s = S_DRAIN;
            end else begin
               rem_s         = rem_r - ROW_W'(1);
               src_rd_en_s   = 1'b1;
               src_rd_addr_s = src_rd_addr_r + AW'(1);
            end
         end
         S_DRAIN: begin
            // Only pool mode has a row still behind the pool register when issue stops.
            if (pool_en_r && pool_in_valid_r) begin
               state_s = S_DRAIN;
            end else begin
               state_s = S_FIN;
            end
         end
         S_FIN: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
      pool_in_valid_s = src_rd_en_r;
      dst_wr_en_s     = pool_en_r ? pool_in_valid_r : src_rd_en_r;
      busy_s          = (state_s != S_IDLE);
      done_s          = (state_s == S_FIN);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r         <= S_IDLE;
         rem_r           <= {ROW_W{1'b0}};
         pool_en_r       <= 1'b0;
         kernel_r        <= {MAX_BITS_POOL{1'b0}};
         src_rd_en_r     <= 1'b0;
         src_rd_addr_r   <= {AW{1'b0}};
         pool_in_valid_r <= 1'b0;
         dst_wr_en_r     <= 1'b0;
         dst_wr_addr_r   <= {AW{1'b0}};
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
         cfg_err_r       <= 1'b0;
      end else begin
         state_r         <= state_s;
         rem_r           <= rem_s;
         pool_en_r       <= pool_en_s;
         kernel_r        <= kernel_s;
         src_rd_en_r     <= src_rd_en_s;
         src_rd_addr_r   <= src_rd_addr_s;
         pool_in_valid_r <= pool_in_valid_s;
         dst_wr_en_r     <= dst_wr_en_s;
         dst_wr_addr_r   <= dst_wr_addr_s;
         busy_r          <= busy_s;
         done_r          <= done_s;
         cfg_err_r       <= cfg_err_s;
      end
   end

   assign bus.src_rd_en        = src_rd_en_r;
   assign bus.src_rd_addr      = src_rd_addr_r;
   assign bus.pool_enable      = pool_en_r;
   assign bus.pool_kernel_size = kernel_r;
   assign bus.pool_in_valid    = pool_in_valid_r;
   assign bus.dst_wr_en        = dst_wr_en_r;
   assign bus.dst_wr_addr      = dst_wr_addr_r;
   assign bus.busy             = busy_r;
   assign bus.done             = done_r;
   assign bus.cfg_err          = cfg_err_r;
endmodule

// File: doc/pool_ctrl.md
# pool_ctrl

Sequencer for the pooling stage. On a start pulse it latches a pool configuration, streams a block of rows from the source buffer through the pool datapath one row per cycle, and writes each result row to the destination buffer. It sits between the top-level control/config registers and the pool unit plus its two SRAM buffers. It owns the pool unit's `enable_pool`, `kernel_size` and `in_data_available` inputs.

## Interface

Parameters:
- `MAX_BITS_POOL`, 3: width of the kernel-size field.
- `ROW_W`, 8: width of the row counter and `num_rows`.
- `AW`, 10: buffer address width.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: synchronous reset, active-low.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `cfg_pool_en` in 1: 1 = pool, 0 = bypass.
- `cfg_kernel_size` in `MAX_BITS_POOL`: legal values 1, 2, 4 (checked only when `cfg_pool_en`=1).
- `cfg_num_rows` in `ROW_W`: number of rows to process; 0 is legal.
- `cfg_src_base` in `AW`: first source address.
- `cfg_dst_base` in `AW`: first destination address.
- `src_rd_en` out 1: source SRAM read strobe; read data is valid 1 cycle later.
- `src_rd_addr` out `AW`: source read address.
- `pool_enable` out 1: drives pool `enable_pool`.
- `pool_kernel_size` out `MAX_BITS_POOL`: drives pool `kernel_size`.
- `pool_in_valid` out 1: drives pool `in_data_available`.
- `dst_wr_en` out 1: destination SRAM write strobe; data comes from pool `out_data`.
- `dst_wr_addr` out `AW`: destination write address.
- `busy` out 1: an operation is in progress.
- `done` out 1: 1-cycle pulse at the end of an operation.
- `cfg_err` out 1: 1-cycle pulse when `start` is rejected.

## Operation

- **FSM states:** IDLE, ISSUE, DRAIN, FIN.
- **IDLE:**
  - `start`=1 with legal config → latch all cfg inputs, go to ISSUE.
  - `start`=1 with `cfg_pool_en`=1 and kernel not in {1,2,4} → pulse `cfg_err` the next cycle, stay in IDLE, latched config unchanged.
  - `start`=1 with `cfg_num_rows`=0 → go straight to FIN (no reads, no writes).
- **ISSUE:**
  - Each cycle: `src_rd_en`=1, `src_rd_addr`=src_base+k, k=0..N-1.
  - After the read with k=N-1 → DRAIN.
- **DRAIN:** wait until the internal write pipeline is empty → FIN.
- **FIN:** `done`=1 for one cycle → IDLE.
- **Config outputs:**
  - `pool_enable` and `pool_kernel_size` are driven from the latched config.
  - They hold steady from the cycle after `start` until the next accepted `start`, including after `done`.
- **Input valid:** `pool_in_valid` is `src_rd_en` delayed 1 cycle, matching SRAM read latency.
- **Write timing:**
  - Derived internally from a valid/address shift pipeline, never from pool `out_data_available`. The pool holds that signal high once set.
  - Pool mode: write at read+2 (1 SRAM + 1 pool register).
  - Bypass mode: write at read+1 (pool is combinational passthrough).
- **Write addresses:** `dst_wr_addr`=dst_base+k, in the same order as reads. Writes are 1 per cycle with no gaps.
- **Address wrap:** address arithmetic is modulo 2^AW; src_base+k past 2^AW-1 wraps to 0.
- **Row counter:** N=2^ROW_W-1 is legal; the counter must not overflow before the last issue.
- **Busy handling:** `start` while not in IDLE is ignored, with no error. Cfg inputs are don't-care outside IDLE.
- **No backpressure:** the destination accepts one write per cycle.

## Timing

- **Reset** (`resetn`=0 at a clk edge, in any state): the next cycle has FSM=IDLE and every output 0 (`src_rd_addr`, `dst_wr_addr`, `pool_kernel_size` included).
  - The pipeline is flushed; in-flight writes are dropped.
  - The latched config is cleared (`pool_enable`=0, i.e. bypass).
- **Accepted start** sampled at edge T:
  - `busy`=1 from T+1 through the FIN cycle inclusive.
  - Read k at cycle T+1+k; `pool_in_valid` at T+2+k.
- **Write k:**
  - Pool mode: at T+3+k. FIN at T+N+3, so `done` is at T+N+3.
  - Bypass mode: at T+2+k. `done` is at T+N+2.
- **N=0:** FIN at T+1 → `done` at T+1, `busy` high only at T+1.
- **Rejected start at T:** `cfg_err`=1 at T+1, `busy` stays 0.
- **Back-to-back:** a `start` sampled in the FIN cycle is ignored. The earliest accepted restart is the first IDLE cycle after FIN.

## Test plan

- **Pool k=2:** reset, then start with pool_en=1, k=2, N=4, src=0x010, dst=0x200.
  - Reads 0x010..0x013 at T+1..T+4; writes 0x200..0x203 at T+3..T+6.
  - `done` at T+7; `pool_kernel_size`=2 stable throughout.
- **Bypass:** pool_en=0, N=3, dst=0x100.
  - Writes at T+2..T+4; `done` at T+5; `pool_enable`=0.
- **Wrap:** src=0x3FE, dst=0x3FF, N=3 (AW=10).
  - Reads 0x3FE, 0x3FF, 0x000; writes 0x3FF, 0x000, 0x001.
- **Illegal and empty configs:**
  - pool_en=1, k=3 → `cfg_err` at T+1, no `src_rd_en`, `busy`=0.
  - pool_en=0, k=3 → accepted.
  - N=0 → `done` at T+1, no reads or writes.
- **Mid-run reset:** N=8; `resetn` low at the edge of the 4th issue cycle.
  - Next cycle all outputs 0, no further writes.
  - A new start with N=2 then completes normally (`done` at T'+5).
- **Ignored start:** `start` pulsed every cycle during an N=5 run.
  - Ignored until IDLE; exactly 5 writes.
  - Second run begins on the first IDLE cycle after `done`.
